// File: rtl/jmb_scanline_output_packer.sv
// Output end of the scanline filter path: counts the filtered output window, packs
// four pixels per 32-bit word and hands words downstream through a first-word-fall-through FIFO.
module jmb_scanline_output_packer #(
  parameter int KERNEL_SIZE = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] width,
  input  logic [31:0] height,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] K        = 32'(KERNEL_SIZE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        armed_q;
  logic [31:0] total_q;
  logic [31:0] pix_cnt_q;
  logic [31:0] pack_q;
  logic [31:0] stage_word_q;
  logic        stage_valid_q;
  logic        stage_last_q;
  logic        overflow_q;
  logic        frame_done_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [32:0] mem [FIFO_DEPTH];

  logic [31:0] total_c;
  logic [31:0] packed_c;
  logic [1:0]  lane;
  logic        start, abort, accept, last_pix;
  logic [AW:0] fifo_cnt;
  logic        fifo_empty, fifo_full;
  logic        pop, push_ok, push_drop;
  logic [32:0] head;

  always_comb begin
    total_c = '0;
    if (width >= K && height >= K)
      total_c = (width - K + 32'd1) * (height - K + 32'd1);
  end

  assign start    = (state_q == S_IDLE) && enable && armed_q;
  assign abort    = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !enable;
  assign accept   = (state_q == S_RUN) && enable && pixel_valid;
  // Lane follows the running pixel count so packing stays continuous across lines.
  assign lane     = pix_cnt_q[1:0];
  assign last_pix = ((pix_cnt_q + 32'd1) == total_q);

  always_comb begin
    packed_c = pack_q;
    packed_c[{lane, 3'b000} +: 8] = pixel_in;
  end

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign pop        = !fifo_empty && word_ready;
  // A full FIFO still accepts the staged word when the head leaves in the same cycle.
  assign push_ok    = stage_valid_q && (!fifo_full || pop) && !abort;
  assign push_drop  = stage_valid_q && fifo_full && !pop && !abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (total_c == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (!enable)                state_d = S_IDLE;
        else if (accept && last_pix) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!enable)                          state_d = S_IDLE;
        else if (!stage_valid_q && fifo_empty) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_q       <= 1'b1;
      total_q       <= '0;
      pix_cnt_q     <= '0;
      pack_q        <= '0;
      stage_word_q  <= '0;
      stage_valid_q <= 1'b0;
      stage_last_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      // A new frame needs enable to be seen low after the previous start.
      if (!enable)    armed_q <= 1'b1;
      else if (start) armed_q <= 1'b0;
      frame_done_q  <= (state_q == S_DONE);
      stage_valid_q <= 1'b0;
      if (start) begin
        total_q    <= total_c;
        pix_cnt_q  <= '0;
        pack_q     <= '0;
        overflow_q <= 1'b0;
      end
      if (abort) begin
        pack_q    <= '0;
        pix_cnt_q <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
      end else begin
        if (accept) begin
          pix_cnt_q <= pix_cnt_q + 32'd1;
          if (lane == 2'd3 || last_pix) begin
            stage_word_q  <= packed_c;
            stage_last_q  <= last_pix;
            stage_valid_q <= 1'b1;
            pack_q        <= '0;
          end else begin
            pack_q <= packed_c;
          end
        end
        if (push_ok)   wr_ptr_q   <= wr_ptr_q + 1'b1;
        if (pop)       rd_ptr_q   <= rd_ptr_q + 1'b1;
        if (push_drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {stage_last_q, stage_word_q};
  end

  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign word_valid = !fifo_empty;
  assign word_out   = word_valid ? head[31:0] : '0;
  assign word_last  = word_valid && head[32];
  assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_jmb_scanline_output_packer.sv
// Directed bench for jmb_scanline_output_packer: frame packing, latency, backpressure,
// overflow, degenerate frame and mid-frame abort.
module tb_jmb_scanline_output_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] width, height;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [32:0] q[$];

  jmb_scanline_output_packer #(.KERNEL_SIZE(3), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .width(width), .height(height),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Handshakes complete on the next rising edge; record them mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (word_valid && word_ready) q.push_back({word_last, word_out});
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = base + 8'(i);
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h);
    width  = 32'(w);
    height = 32'(h);
    enable = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    enable = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int j, input int total);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      if (4*j + k < total) w[8*k +: 8] = base + 8'(4*j + k);
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; width = '0; height = '0;
    pixel_in = '0; pixel_valid = 1'b0; word_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({word_out, word_valid, word_last, busy, frame_done, overflow} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {word_out, word_valid, word_last, busy, frame_done, overflow});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    int b, d;
    b = q.size(); d = done_cnt;
    word_ready = 1'b1;
    start_frame(15, 10);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b expected 1", busy); end
    send(104, 8'h40);
    for (int i = 0; i < 100 && done_cnt == d; i++) tick();
    tick(); tick();
    checks++;
    if (q.size() - b !== 26) begin
      failures++; $display("FAIL t1_word_count: got %0d expected 26", q.size() - b);
    end
    for (int j = 0; j < 26 && b + j < q.size(); j++) begin
      checks++;
      if (q[b+j] !== {(j == 25), exp_word(8'h40, j, 104)}) begin
        failures++;
        $display("FAIL t1_word%0d: got %h expected %h", j, q[b+j], {(j == 25), exp_word(8'h40, j, 104)});
      end
    end
    checks++;
    if (done_cnt - d !== 1) begin
      failures++; $display("FAIL t1_frame_done: got %0d pulses expected 1", done_cnt - d);
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL t1_idle: got busy=%b overflow=%b expected 0 0", busy, overflow);
    end
    end_frame();
  endtask

  task automatic test_partial_word();
    int b, d;
    b = q.size(); d = done_cnt;
    word_ready = 1'b1;
    start_frame(7, 4);
    send(4, 8'h10);
    checks++;
    if (word_valid !== 1'b0) begin
      failures++; $display("FAIL t2_latency_early: got word_valid=%b expected 0", word_valid);
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h13121110) begin
      failures++;
      $display("FAIL t2_latency: got valid=%b word=%h expected 1 13121110", word_valid, word_out);
    end
    send(6, 8'h14);
    for (int i = 0; i < 40 && done_cnt == d; i++) tick();
    checks++;
    if (q.size() - b !== 3) begin
      failures++; $display("FAIL t2_word_count: got %0d expected 3", q.size() - b);
    end else begin
      checks++;
      if (q[b] !== {1'b0, 32'h13121110} || q[b+1] !== {1'b0, 32'h17161514}) begin
        failures++; $display("FAIL t2_full_words: got %h %h expected 013121110 017161514", q[b], q[b+1]);
      end
      checks++;
      if (q[b+2] !== {1'b1, 16'h0, 8'h19, 8'h18}) begin
        failures++; $display("FAIL t2_last_word: got %h expected 100001918", q[b+2]);
      end
    end
    checks++;
    if (done_cnt - d !== 1) begin
      failures++; $display("FAIL t2_frame_done: got %0d pulses expected 1", done_cnt - d);
    end
    end_frame();
  endtask

  task automatic test_backpressure();
    int b, d;
    logic [31:0] held;
    b = q.size(); d = done_cnt;
    word_ready = 1'b0;
    start_frame(6, 5);
    send(12, 8'h80);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h83828180 || word_last !== 1'b0) begin
      failures++;
      $display("FAIL t3_head: got valid=%b word=%h last=%b expected 1 83828180 0",
               word_valid, word_out, word_last);
    end
    held = word_out;
    tick(); tick();
    checks++;
    if (word_out !== held) begin
      failures++; $display("FAIL t3_stable: got %h expected %h", word_out, held);
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1 || done_cnt != d || q.size() != b) begin
      failures++;
      $display("FAIL t3_stalled: got overflow=%b busy=%b done=%0d words=%0d expected 0 1 0 0",
               overflow, busy, done_cnt - d, q.size() - b);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 40 && done_cnt == d; i++) tick();
    checks++;
    if (q.size() - b !== 3) begin
      failures++; $display("FAIL t3_word_count: got %0d expected 3", q.size() - b);
    end
    for (int j = 0; j < 3 && b + j < q.size(); j++) begin
      checks++;
      if (q[b+j] !== {(j == 2), exp_word(8'h80, j, 12)}) begin
        failures++;
        $display("FAIL t3_word%0d: got %h expected %h", j, q[b+j], {(j == 2), exp_word(8'h80, j, 12)});
      end
    end
    checks++;
    if (done_cnt - d !== 1) begin
      failures++; $display("FAIL t3_frame_done: got %0d pulses expected 1", done_cnt - d);
    end
    end_frame();
  endtask

  task automatic test_overflow();
    int b, d;
    b = q.size(); d = done_cnt;
    word_ready = 1'b0;
    start_frame(40, 3);
    send(38, 8'h00);
    tick(); tick(); tick();
    checks++;
    if (overflow !== 1'b1 || word_valid !== 1'b1) begin
      failures++; $display("FAIL t4_overflow: got overflow=%b valid=%b expected 1 1", overflow, word_valid);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 40 && done_cnt == d; i++) tick();
    checks++;
    if (q.size() - b !== 8) begin
      failures++; $display("FAIL t4_word_count: got %0d expected 8", q.size() - b);
    end
    for (int j = 0; j < 8 && b + j < q.size(); j++) begin
      checks++;
      if (q[b+j] !== {1'b0, exp_word(8'h00, j, 38)}) begin
        failures++;
        $display("FAIL t4_word%0d: got %h expected %h", j, q[b+j], {1'b0, exp_word(8'h00, j, 38)});
      end
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || done_cnt - d !== 1) begin
      failures++;
      $display("FAIL t4_sticky: got overflow=%b done=%0d expected 1 1", overflow, done_cnt - d);
    end
    end_frame();
  endtask

  task automatic test_small_frame();
    int b;
    b = q.size();
    word_ready = 1'b1;
    start_frame(2, 10);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t5_cycle1: got done=%b busy=%b expected 0 0", frame_done, busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      failures++; $display("FAIL t5_done_pulse: got %b expected 1", frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || q.size() != b || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL t5_after: got done=%b words=%0d valid=%b expected 0 0 0",
               frame_done, q.size() - b, word_valid);
    end
    end_frame();
  endtask

  task automatic test_abort_restart();
    int b, d;
    d = done_cnt;
    word_ready = 1'b0;
    start_frame(6, 5);
    send(5, 8'h55);
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0) begin
      failures++; $display("FAIL t6_abort: got busy=%b valid=%b expected 0 0", busy, word_valid);
    end
    tick();
    word_ready = 1'b1;
    b = q.size();
    start_frame(6, 5);
    checks++;
    if (overflow !== 1'b0 || word_valid !== 1'b0) begin
      failures++; $display("FAIL t6_restart: got overflow=%b valid=%b expected 0 0", overflow, word_valid);
    end
    send(12, 8'hA0);
    for (int i = 0; i < 40 && done_cnt == d; i++) tick();
    checks++;
    if (q.size() - b !== 3) begin
      failures++; $display("FAIL t6_word_count: got %0d expected 3", q.size() - b);
    end
    for (int j = 0; j < 3 && b + j < q.size(); j++) begin
      checks++;
      if (q[b+j] !== {(j == 2), exp_word(8'hA0, j, 12)}) begin
        failures++;
        $display("FAIL t6_word%0d: got %h expected %h", j, q[b+j], {(j == 2), exp_word(8'hA0, j, 12)});
      end
    end
    checks++;
    if (done_cnt - d !== 1) begin
      failures++; $display("FAIL t6_frame_done: got %0d pulses expected 1", done_cnt - d);
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_word();
    test_backpressure();
    test_overflow();
    test_small_frame();
    test_abort_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
